// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the MEM-stage access unit and its lane aligner:
// load/store opcodes, FSM state encoding, access size encoding and a helper
// that derives the access size from the instruction opcode.
// ---------------------------------------------------------------------------
package mem_pkg;

    localparam logic [5:0] OP_LB = 6'h20;
    localparam logic [5:0] OP_LW = 6'h23;
    localparam logic [5:0] OP_SB = 6'h28;
    localparam logic [5:0] OP_SW = 6'h2b;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_e;

    typedef enum logic {
        SZ_BYTE = 1'b0,
        SZ_WORD = 1'b1
    } size_e;

    // Word accesses are the opcodes whose two low bits are set (lw, sw).
    function automatic size_e size_of(input logic [5:0] opcode);
        return (opcode[1:0] == 2'b11) ? SZ_WORD : SZ_BYTE;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// ---------------------------------------------------------------------------
// mem_lane_align
// Combinational byte-lane steering for a little-endian 32-bit data bus.
// Kept free of state so the instruction-fetch path can reuse it.
//
// Ports:
//   lane_i   : byte offset within the word (addr[1:0])
//   size_i   : access size (byte / word)
//   wdata_i  : raw store data
//   rdata_i  : raw bus read data
//   wstrb_o  : byte enables for a store of this size/lane
//   wdata_o  : store data replicated across all lanes (byte) or passed (word)
//   rdata_o  : load data, sign-extended from the selected lane for bytes
// ---------------------------------------------------------------------------
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  lane_i,
    input  size_e       size_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0] rbyte;

    always_comb begin
        rbyte = rdata_i[7:0];
        case (lane_i)
            2'd0: rbyte = rdata_i[7:0];
            2'd1: rbyte = rdata_i[15:8];
            2'd2: rbyte = rdata_i[23:16];
            2'd3: rbyte = rdata_i[31:24];
            default: rbyte = rdata_i[7:0];
        endcase
    end

    always_comb begin
        wstrb_o = 4'hF;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
        if (size_i == SZ_BYTE) begin
            wstrb_o = 4'b0001 << lane_i;
            wdata_o = {4{wdata_i[7:0]}};
            rdata_o = {{24{rbyte[7]}}, rbyte};
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// MEM-stage access unit. Accepts one operation per valid/ready handshake,
// performs lb/lw/sb/sw over a request/ack bus with a wait-cycle timeout and
// returns a registered one-cycle result to writeback. Non-memory ops pass
// their ALU value straight through; misaligned words, load+store conflicts
// and bus timeouts return out_err_o with zero data.
//
// Ports:
//   clk_i, rst_i              : clock, synchronous active-high reset
//   in_valid_i / in_ready_o   : operation handshake from EX/MEM
//   load_i, store_i, opcode_i : decoder flags and opcode
//   addr_i, wdata_i           : effective address / ALU value, store data
//   out_valid_o, out_data_o,
//   out_err_o                 : registered result pulse to writeback
//   mem_req_o ... mem_wstrb_o : data bus request, held while in BUS
//   mem_ack_i, mem_rdata_i    : bus completion and read data
//
// State | meaning
//   IDLE | ready for a new operation; single-cycle ops complete here
//   BUS  | memory request outstanding, waiting for ack or timeout
// ---------------------------------------------------------------------------
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic        load_i,
    input  logic        store_i,
    input  logic [5:0]  opcode_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        out_valid_o,
    output logic [31:0] out_data_o,
    output logic        out_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    // Value held by the counter during the last no-ack cycle before abort.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [31:0]       maddr_q, maddr_d;
    logic [31:0]       mwdata_q, mwdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    size_e             size_q, size_d;
    logic [1:0]        lane_q, lane_d;
    logic              ovalid_q, ovalid_d;
    logic [31:0]       odata_q, odata_d;
    logic              oerr_q, oerr_d;

    logic              accept;
    size_e             in_size;
    logic              misaligned;

    logic [1:0]        al_lane;
    size_e             al_size;
    logic [3:0]        al_wstrb;
    logic [31:0]       al_wdata;
    logic [31:0]       al_rdata;

    assign in_ready_o = (state_q == IDLE);
    assign accept     = in_valid_i && in_ready_o;
    assign in_size    = size_of(opcode_i);
    assign misaligned = (in_size == SZ_WORD) && (addr_i[1:0] != 2'b00);

    // One aligner serves both directions: store steering is only needed at
    // accept (IDLE, live inputs), load extraction only on ack (BUS, latched).
    assign al_lane = (state_q == BUS) ? lane_q : addr_i[1:0];
    assign al_size = (state_q == BUS) ? size_q : in_size;

    mem_lane_align u_lane_align (
        .lane_i  (al_lane),
        .size_i  (al_size),
        .wdata_i (wdata_i),
        .rdata_i (mem_rdata_i),
        .wstrb_o (al_wstrb),
        .wdata_o (al_wdata),
        .rdata_o (al_rdata)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        we_d     = we_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        wstrb_d  = wstrb_q;
        size_d   = size_q;
        lane_d   = lane_q;
        ovalid_d = 1'b0;
        odata_d  = 32'h0;
        oerr_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d = '0;
                    if (!load_i && !store_i) begin
                        ovalid_d = 1'b1;
                        odata_d  = addr_i;
                    end else if ((load_i && store_i) || misaligned) begin
                        ovalid_d = 1'b1;
                        oerr_d   = 1'b1;
                    end else begin
                        state_d  = BUS;
                        req_d    = 1'b1;
                        we_d     = store_i;
                        maddr_d  = {addr_i[31:2], 2'b00};
                        mwdata_d = store_i ? al_wdata : 32'h0;
                        wstrb_d  = store_i ? al_wstrb : 4'h0;
                        size_d   = in_size;
                        lane_d   = addr_i[1:0];
                    end
                end
            end
            BUS: begin
                if (mem_ack_i) begin
                    state_d  = IDLE;
                    req_d    = 1'b0;
                    ovalid_d = 1'b1;
                    odata_d  = we_q ? 32'h0 : al_rdata;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = IDLE;
                    req_d    = 1'b0;
                    ovalid_d = 1'b1;
                    oerr_d   = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            maddr_q  <= 32'h0;
            mwdata_q <= 32'h0;
            wstrb_q  <= 4'h0;
            size_q   <= SZ_BYTE;
            lane_q   <= 2'b00;
            ovalid_q <= 1'b0;
            odata_q  <= 32'h0;
            oerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            we_q     <= we_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            wstrb_q  <= wstrb_d;
            size_q   <= size_d;
            lane_q   <= lane_d;
            ovalid_q <= ovalid_d;
            odata_q  <= odata_d;
            oerr_q   <= oerr_d;
        end
    end

    assign out_valid_o = ovalid_q;
    assign out_data_o  = odata_q;
    assign out_err_o   = oerr_q;
    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = maddr_q;
    assign mem_wdata_o = mwdata_q;
    assign mem_wstrb_o = wstrb_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage access unit of the MIPS pipeline, directly downstream of the load/store opcode decoder. It takes one operation per handshake from the EX/MEM boundary and performs the data-memory transaction for lb/lw/sb/sw over a variable-latency request/ack bus. It returns a registered result (aligned, sign-extended load data or passed-through ALU value) to writeback. It flags misaligned word accesses, illegal load+store combinations and bus timeouts.

## Interface
- MAX_WAIT, 15: bus cycles without ack before the transaction is aborted with error (≥1)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operation present at the MEM stage
- in_ready  out  1  unit can accept an operation this cycle
- load  in  1  decoder load flag (opcodes 0x20, 0x23)
- store  in  1  decoder store flag (opcodes 0x28, 0x2b)
- opcode  in  6  instruction opcode; opcode[1:0]==2'b11 → word, else byte
- addr  in  32  effective address (ALU result for non-memory ops)
- wdata  in  32  store data (rt)
- out_valid  out  1  one-cycle result pulse
- out_data  out  32  load result or passed-through addr
- out_err  out  1  qualifies out_valid: operation faulted
- mem_req  out  1  bus request, held until mem_ack or abort
- mem_we  out  1  write request
- mem_addr  out  32  word-aligned address {addr[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte enables, little-endian lanes
- mem_ack  in  1  bus completes transaction this cycle
- mem_rdata  in  32  read data, valid with mem_ack

## Operation
- States: IDLE, BUS. in_ready = (state==IDLE).
- Accept = in_valid & in_ready. All mem_* outputs are registered at accept and held stable throughout BUS.
- Accept, load=store=0: next cycle out_valid=1, out_data=addr, out_err=0; state stays IDLE.
- Accept, load=store=1: next cycle out_valid=1, out_err=1, out_data=0; no bus request.
- Accept, word op with addr[1:0]≠0: next cycle out_valid=1, out_err=1, out_data=0; no bus request.
- Accept, valid memory op: go to BUS with mem_req=1 and mem_we=store.
- Byte store: mem_wdata={4{wdata[7:0]}}, mem_wstrb=4'b0001<<addr[1:0].
- Word store: mem_wdata=wdata, mem_wstrb=4'hF.
- Loads: mem_wstrb=0.
- BUS, mem_ack=1: mem_req drops next cycle, state→IDLE, out_valid=1 next cycle, out_err=0.
  - lw: out_data=mem_rdata.
  - lb: out_data=sign-extended byte from lane addr[1:0].
  - Stores: out_data=0.
- BUS, no ack: wait counter increments. The MAX_WAIT-th consecutive no-ack cycle aborts: mem_req drops, state→IDLE, out_valid=1 with out_err=1, out_data=0. If ack arrives on the abort cycle, ack wins.
- Counter clears on every accept; width $clog2(MAX_WAIT+1).
- out_valid/out_err/out_data are registered; outside out_valid, out_err=0 and out_data holds 0.

## Timing
- Reset values: state IDLE, in_ready=1 from the first cycle after reset, and all other outputs and the counter at 0.
- Non-memory or faulting op accepted at T: out_valid at T+1. Back-to-back acceptance every cycle.
- Memory op accepted at T: mem_req high from T+1. Ack at cycle A≥T+1 gives out_valid at A+1, and in_ready is high again at A+1.
- Minimum memory latency is 2 cycles; throughput is one memory op per 2 cycles.
- mem_ack sampled only in BUS; an ack in IDLE is ignored.
- rst asserted mid-BUS: mem_req is low from the next cycle and the transaction is abandoned with no out_valid. The bus must tolerate a dropped request.
- in_valid while in_ready=0 is not accepted. Upstream holds its inputs stable.

## Structure
- Shared package mem_pkg: OP_LB=6'h20, OP_LW=6'h23, OP_SB=6'h28, OP_SW=6'h2b; state enum {IDLE, BUS}; size encoding.
- Sub-module mem_lane_align (combinational): addr[1:0], size, wdata, rdata → wstrb, lane-replicated wdata, sign-extended load data. Reused by an instruction-fetch path later.
- Top holds the FSM, wait counter and output registers.

## Test plan
- Non-memory op addr=0x0000_1234 on three consecutive cycles → three consecutive out_valid pulses with out_data=0x1234 and err=0.
- lb, addr=0x103, mem_rdata=0x80FF_0011, ack one cycle after req → mem_addr=0x100, wstrb=0, out_data=0xFFFF_FF80 two cycles after accept.
- sb, addr=0x202, wdata=0xAABB_CC5A → mem_we=1, mem_wdata=0x5A5A_5A5A, mem_wstrb=4'b0100; sw, addr=0x200 → wstrb=4'hF.
- lw, addr=0x0000_0006 → no mem_req; out_valid with out_err=1 at T+1. load=store=1 → same.
- MAX_WAIT=4 with ack never asserted → mem_req high for exactly 4 cycles, then out_err pulse. Repeat with ack on the 4th cycle → normal completion, err=0.
- rst pulsed on the 2nd BUS cycle with ack arriving later → mem_req low after rst, no out_valid, in_ready=1. A following sw completes normally.
